// File: rtl/ladder_sequencer.sv
// Montgomery ladder sequencer for X25519 scalar multiplication.
// Holds the projective ladder state (X2,Z2,X3,Z3), performs the conditional
// swap ahead of every ladder step, hands each step to an external datapath,
// and returns the projective x-only result after the final swap.
module ladder_sequencer #(
  parameter int WIDTH = 256,
  parameter int NBITS = 255,
  parameter bit CLAMP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] u,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] z_out,
  output logic             step_go,
  output logic [WIDTH-1:0] step_x1,
  output logic [WIDTH-1:0] step_x2,
  output logic [WIDTH-1:0] step_z2,
  output logic [WIDTH-1:0] step_x3,
  output logic [WIDTH-1:0] step_z3,
  input  logic             step_done,
  input  logic [WIDTH-1:0] step_x2n,
  input  logic [WIDTH-1:0] step_z2n,
  input  logic [WIDTH-1:0] step_x3n,
  input  logic [WIDTH-1:0] step_z3n
);

  localparam int TW = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWAP,
    S_ISSUE,
    S_WAIT,
    S_FINAL,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] ks;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] x2, z2, x3, z3;
  logic [TW-1:0]    t;
  logic             swap;

  // RFC 7748 scalar clamp: multiple of the cofactor, top bit fixed at 254.
  function automatic logic [WIDTH-1:0] clamp_scalar(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    r        = s;
    r[2:0]   = 3'b000;
    r[255]   = 1'b0;
    r[254]   = 1'b1;
    return r;
  endfunction

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; this is also what makes the pair exchanges below work.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Next-state logic; outputs are pure decodes of the registered state.
  // NOTE: state_n gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = S_SWAP;
      S_SWAP:  state_n = S_ISSUE;
      S_ISSUE: state_n = S_WAIT;
      S_WAIT:  if (step_done) state_n = (t == '0) ? S_FINAL : S_SWAP;
      S_FINAL: state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign step_go = (state == S_ISSUE);
  assign step_x1 = x1;
  assign step_x2 = x2;
  assign step_z2 = z2;
  assign step_x3 = x3;
  assign step_z3 = z3;

  // Ladder datapath: capture, conditional swaps, step write-back, result load.
  // NOTE: the wide ladder registers are deliberately reset so a reset mid-run
  // leaves no stale point data visible on the step or result ports.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ks    <= '0;
      x1    <= '0;
      x2    <= '0;
      z2    <= '0;
      x3    <= '0;
      z3    <= '0;
      swap  <= 1'b0;
      t     <= TW'(NBITS - 1);
      x_out <= '0;
      z_out <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            ks   <= CLAMP ? clamp_scalar(k) : k;
            x1   <= u;
            x2   <= WIDTH'(1);
            z2   <= '0;
            x3   <= u;
            z3   <= WIDTH'(1);
            swap <= 1'b0;
            t    <= TW'(NBITS - 1);
          end
        end
        S_SWAP: begin
          if (swap ^ ks[t]) begin
            x2 <= x3;
            z2 <= z3;
            x3 <= x2;
            z3 <= z2;
          end
          swap <= ks[t];
        end
        S_WAIT: begin
          if (step_done) begin
            x2 <= step_x2n;
            z2 <= step_z2n;
            x3 <= step_x3n;
            z3 <= step_z3n;
            if (t != '0) t <= t - 1'b1;
          end
        end
        S_FINAL: begin
          if (swap) begin
            x2 <= x3;
            z2 <= z3;
            x3 <= x2;
            z3 <= z2;
          end
          x_out <= swap ? x3 : x2;
          z_out <= swap ? z3 : z2;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ladder_sequencer.sv
// Directed bench for ladder_sequencer: one raw-scalar and one clamped
// instance, each served by a latency-programmable step responder that
// either echoes its operands or applies a deliberately asymmetric mix.
module tb_ladder_sequencer;

  localparam logic [255:0] K_A5  = {32{8'hA5}};
  localparam logic [255:0] JUNK  = {64{4'hD}};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         inj = 1'b0;
  logic [255:0] k_in = '0;
  logic [255:0] u_in = '0;

  logic         busy[2], done[2], step_go[2], step_done[2], r_done[2];
  logic [255:0] x_out[2], z_out[2];
  logic [255:0] sx1[2], sx2[2], sz2[2], sx3[2], sz3[2];
  logic [255:0] nx2[2], nz2[2], nx3[2], nz3[2];
  logic [255:0] rx2[2], rz2[2], rx3[2], rz3[2];
  logic [255:0] cx1[2], cx2[2], cz2[2], cx3[2], cz3[2];
  logic [255:0] fx2[2], fz2[2], fx3[2], fz3[2];
  int           pend[2];
  int           seen_id[2];

  int  lat = 1;
  bit  mix = 1'b0;
  int  run_id = 0;
  int  go_total = 0;
  int  stab_err = 0;
  int  nchk = 0;
  int  nfail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_mux
    assign step_done[g] = r_done[g] | inj;
    assign nx2[g] = inj ? JUNK : rx2[g];
    assign nz2[g] = inj ? JUNK : rz2[g];
    assign nx3[g] = inj ? JUNK : rx3[g];
    assign nz3[g] = inj ? JUNK : rz3[g];
  end

  ladder_sequencer #(.WIDTH(256), .NBITS(255), .CLAMP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .k(k_in), .u(u_in),
    .busy(busy[0]), .done(done[0]), .x_out(x_out[0]), .z_out(z_out[0]),
    .step_go(step_go[0]), .step_x1(sx1[0]), .step_x2(sx2[0]), .step_z2(sz2[0]),
    .step_x3(sx3[0]), .step_z3(sz3[0]), .step_done(step_done[0]),
    .step_x2n(nx2[0]), .step_z2n(nz2[0]), .step_x3n(nx3[0]), .step_z3n(nz3[0])
  );

  ladder_sequencer #(.WIDTH(256), .NBITS(255), .CLAMP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .k(k_in), .u(u_in),
    .busy(busy[1]), .done(done[1]), .x_out(x_out[1]), .z_out(z_out[1]),
    .step_go(step_go[1]), .step_x1(sx1[1]), .step_x2(sx2[1]), .step_z2(sz2[1]),
    .step_x3(sx3[1]), .step_z3(sz3[1]), .step_done(step_done[1]),
    .step_x2n(nx2[1]), .step_z2n(nz2[1]), .step_x3n(nx3[1]), .step_z3n(nz3[1])
  );

  // Stand-in ladder step: echo, or a mix whose halves differ so swaps matter.
  function automatic logic [1023:0] stepf(input logic [255:0] x1, x2, z2, x3, z3,
                                          input bit m);
    logic [255:0] a, b, c, d;
    if (!m) return {x2, z2, x3, z3};
    a = x2 + (x3 << 1) + 256'd1;
    b = z2 + x1;
    c = x3 ^ x2;
    d = z3 + 256'd3;
    return {a, b, c, d};
  endfunction

  // Reference ladder (RFC 7748 order) driving the same stand-in step.
  function automatic logic [511:0] model(input logic [255:0] k, u, input bit clamp,
                                         input bit m);
    logic [255:0]  kk, x2, z2, x3, z3, tx, tz;
    logic [1023:0] r;
    bit            sw, b;
    kk = k;
    if (clamp) begin
      kk[2:0] = 3'b000;
      kk[255] = 1'b0;
      kk[254] = 1'b1;
    end
    x2 = 256'd1; z2 = '0; x3 = u; z3 = 256'd1; sw = 1'b0;
    for (int t = 254; t >= 0; t--) begin
      b = kk[t];
      if (sw ^ b) begin
        tx = x2; tz = z2; x2 = x3; z2 = z3; x3 = tx; z3 = tz;
      end
      sw = b;
      r = stepf(u, x2, z2, x3, z3, m);
      {x2, z2, x3, z3} = r;
    end
    if (sw) begin
      tx = x2; tz = z2; x2 = x3; z2 = z3; x3 = tx; z3 = tz;
    end
    return {x2, z2};
  endfunction

  // Step responder: answers each step_go after lat cycles and watches that
  // operands stay put for the whole wait.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      r_done[i] = 1'b0;
      if (!rst) begin
        pend[i] = 0;
      end else if (step_go[i] === 1'b1) begin
        pend[i] = lat;
        cx1[i] = sx1[i]; cx2[i] = sx2[i]; cz2[i] = sz2[i];
        cx3[i] = sx3[i]; cz3[i] = sz3[i];
        if (i == 0) go_total++;
        if (seen_id[i] != run_id) begin
          seen_id[i] = run_id;
          fx2[i] = sx2[i]; fz2[i] = sz2[i]; fx3[i] = sx3[i]; fz3[i] = sz3[i];
        end
      end else if (pend[i] > 0) begin
        if ({sx1[i], sx2[i], sz2[i], sx3[i], sz3[i]} !==
            {cx1[i], cx2[i], cz2[i], cx3[i], cz3[i]}) stab_err++;
        pend[i]--;
        if (pend[i] == 0) begin
          r_done[i] = 1'b1;
          {rx2[i], rz2[i], rx3[i], rz3[i]} = stepf(cx1[i], cx2[i], cz2[i], cx3[i], cz3[i], mix);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one multiplication and wait (bounded) for done on the raw instance.
  // With disturb set: step_done pulsed in SWAP, start re-asserted with new
  // operands mid-run and in the DONE cycle.
  task automatic run(input logic [255:0] k, input logic [255:0] u, input bit disturb,
                     output int cyc, output int gos, output int busy_drop);
    int base;
    @(negedge clk);
    run_id++;
    base  = go_total;
    start = 1'b1;
    k_in  = k;
    u_in  = u;
    @(negedge clk);
    start = 1'b0;
    if (disturb) inj = 1'b1;
    cyc = 1;
    busy_drop = 0;
    while (done[0] !== 1'b1 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      inj = 1'b0;
      if (disturb) begin
        if (busy[0] !== 1'b1) busy_drop++;
        if (cyc % 50 == 0) begin
          start = 1'b1;
          k_in  = ~k_in;
          u_in  = u_in + 256'd5;
        end else begin
          start = 1'b0;
        end
      end
    end
    gos = go_total - base;
    start = disturb;
  endtask

  logic [511:0] exp0, exp1;
  int           cyc, gos, bd;

  initial begin
    for (int i = 0; i < 2; i++) begin
      r_done[i] = 1'b0; pend[i] = 0; seen_id[i] = 0;
      rx2[i] = '0; rz2[i] = '0; rx3[i] = '0; rz3[i] = '0;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy",  256'(busy[0]), 256'd0);
    chk("rst_done",  256'(done[0]), 256'd0);
    chk("rst_go",    256'(step_go[0]), 256'd0);
    chk("rst_x_out", x_out[0], 256'd0);
    chk("rst_z_out", z_out[1], 256'd0);
    chk("rst_x2",    sx2[0], 256'd0);
    rst = 1'b1;

    // Echo stub, L=1: swaps cancel, 767-cycle latency, 255 step issues.
    lat = 1; mix = 1'b0;
    run(K_A5, 256'd9, 1'b0, cyc, gos, bd);
    chk("t1_done_cycle", 256'(cyc), 256'd767);
    chk("t1_go_count", 256'(gos), 256'd255);
    chk("t1_x_out", x_out[0], 256'd1);
    chk("t1_z_out", z_out[0], 256'd0);
    @(negedge clk);
    chk("t1_done_pulse", 256'(done[0]), 256'd0);
    chk("t1_busy_after", 256'(busy[0]), 256'd0);
    chk("t1_x_hold", x_out[0], 256'd1);

    // Mixing stub: k=1 and k=2 against the reference ladder.
    mix = 1'b1;
    run(256'd1, 256'd9, 1'b0, cyc, gos, bd);
    exp0 = model(256'd1, 256'd9, 1'b0, 1'b1);
    chk("t2_k1_x", x_out[0], exp0[511:256]);
    chk("t2_k1_z", z_out[0], exp0[255:0]);
    run(256'd2, 256'd9, 1'b0, cyc, gos, bd);
    exp0 = model(256'd2, 256'd9, 1'b0, 1'b1);
    exp1 = model(256'd2, 256'd9, 1'b1, 1'b1);
    chk("t2_k2_x", x_out[0], exp0[511:256]);
    chk("t2_k2_z", z_out[0], exp0[255:0]);
    chk("t2_k2_clamp_x", x_out[1], exp1[511:256]);
    chk("t2_k2_clamp_z", z_out[1], exp1[255:0]);

    // Longer step latency: per-bit cost L+2, operands held through the wait.
    lat = 4; mix = 1'b0;
    run(K_A5, 256'd9, 1'b0, cyc, gos, bd);
    chk("t3_L4_done_cycle", 256'(cyc), 256'd1532);
    chk("t3_L4_x_out", x_out[0], 256'd1);
    lat = 3; mix = 1'b1;
    run(K_A5, 256'd77, 1'b0, cyc, gos, bd);
    exp0 = model(K_A5, 256'd77, 1'b0, 1'b1);
    chk("t3_L3_done_cycle", 256'(cyc), 256'd1277);
    chk("t3_L3_x_out", x_out[0], exp0[511:256]);
    chk("t3_L3_z_out", z_out[0], exp0[255:0]);

    // Clamp: all-ones and all-zeros scalars, first-step operand trace.
    lat = 1;
    run('1, 256'd9, 1'b0, cyc, gos, bd);
    chk("t4_first_x2", fx2[1], 256'd9);
    chk("t4_first_z2", fz2[1], 256'd1);
    chk("t4_first_x3", fx3[1], 256'd1);
    chk("t4_first_z3", fz3[1], 256'd0);
    exp1 = model('1, 256'd9, 1'b1, 1'b1);
    chk("t4_ones_clamp_x", x_out[1], exp1[511:256]);
    chk("t4_ones_clamp_z", z_out[1], exp1[255:0]);
    run(256'd0, 256'd9, 1'b0, cyc, gos, bd);
    chk("t4_zero_raw_first_x2", fx2[0], 256'd1);
    chk("t4_zero_clamp_first_x2", fx2[1], 256'd9);
    exp0 = model(256'd0, 256'd9, 1'b0, 1'b1);
    exp1 = model(256'd0, 256'd9, 1'b1, 1'b1);
    chk("t4_zero_raw_x", x_out[0], exp0[511:256]);
    chk("t4_zero_clamp_x", x_out[1], exp1[511:256]);
    chk("t4_zero_clamp_z", z_out[1], exp1[255:0]);

    // Stray step_done in IDLE must not disturb anything.
    @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    @(negedge clk);
    chk("t5_idle_inj_busy", 256'(busy[0]), 256'd0);
    chk("t5_idle_inj_x_out", x_out[0], exp0[511:256]);

    // Start re-asserted mid-run and in DONE, step_done pulsed in SWAP.
    run(K_A5, 256'd9, 1'b1, cyc, gos, bd);
    exp0 = model(K_A5, 256'd9, 1'b0, 1'b1);
    chk("t5_done_cycle", 256'(cyc), 256'd767);
    chk("t5_busy_held", 256'(bd), 256'd0);
    chk("t5_x_out", x_out[0], exp0[511:256]);
    chk("t5_z_out", z_out[0], exp0[255:0]);
    @(negedge clk);
    start = 1'b0;
    chk("t5_start_in_done_ignored", 256'(busy[0]), 256'd0);

    // Reset mid-run at bit 100, then a fresh run.
    @(negedge clk);
    run_id++;
    gos   = go_total;
    start = 1'b1;
    k_in  = K_A5;
    u_in  = 256'd9;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (go_total - gos < 155 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_reached_bit100", 256'(go_total - gos), 256'd155);
    rst = 1'b0;
    #1;
    chk("t6_busy", 256'(busy[0]), 256'd0);
    chk("t6_x_out", x_out[0], 256'd0);
    chk("t6_z_out", z_out[0], 256'd0);
    chk("t6_go", 256'(step_go[0]), 256'd0);
    @(negedge clk);
    rst = 1'b1;
    run(256'd2, 256'd9, 1'b0, cyc, gos, bd);
    exp0 = model(256'd2, 256'd9, 1'b0, 1'b1);
    chk("t6_restart_cycle", 256'(cyc), 256'd767);
    chk("t6_restart_x", x_out[0], exp0[511:256]);
    chk("t6_restart_z", z_out[0], exp0[255:0]);

    chk("operand_stability", 256'(stab_err), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
